// File: rtl/dmem_dump_unit.sv
// Data memory read-out engine: stalls the CPU, streams a window of words with their
// addresses over valid/ready, and keeps a modulo-2**DATA_W checksum of emitted words.
module dmem_dump_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    input  logic              cpu_held,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Read in flight: data appears on mem_rdata the cycle after issue.
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_last_q, pend_last_d;

    // Two-entry output buffer kept as a shift register; entry 0 is always the head.
    logic              v0_q, v0_d, v1_q, v1_d;
    logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d;
    logic              l0_q, l0_d, l1_q, l1_d;

    logic              pop_c;
    logic [1:0]        slots_c;
    logic              issue_c;
    logic              issue_last_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Issue decision counts the pop of this cycle so a full-rate stream never stalls.
    always_comb begin
        pop_c        = v0_q & out_ready;
        slots_c      = 2'(v0_q) + 2'(v1_q) + 2'(pend_q) - 2'(pop_c);
        rd_addr_c    = base_q + issued_q[ADDR_W-1:0];
        issue_c      = (state_q == S_READ) && (issued_q != count_q) && (slots_c < 2'd2);
        issue_last_c = (issued_q == count_q - CNT_W'(1));
    end

    // Output buffer update: pop shifts entry 1 forward, captured data fills the first free slot.
    always_comb begin
        v0_d = v0_q;
        d0_d = d0_q;
        a0_d = a0_q;
        l0_d = l0_q;
        v1_d = v1_q;
        d1_d = d1_q;
        a1_d = a1_q;
        l1_d = l1_q;
        if (pop_c) begin
            v0_d = v1_q;
            d0_d = d1_q;
            a0_d = a1_q;
            l0_d = l1_q;
            v1_d = 1'b0;
        end
        if (pend_q) begin
            if (!v0_d) begin
                v0_d = 1'b1;
                d0_d = mem_rdata;
                a0_d = pend_addr_q;
                l0_d = pend_last_q;
            end else begin
                v1_d = 1'b1;
                d1_d = mem_rdata;
                a1_d = pend_addr_q;
                l1_d = pend_last_q;
            end
        end
        pend_d      = issue_c;
        pend_addr_d = issue_c ? rd_addr_c : pend_addr_q;
        pend_last_d = issue_c ? issue_last_c : pend_last_q;
    end

    // Control FSM next-state and registered control outputs.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        issued_d = issue_c ? issued_q + CNT_W'(1) : issued_q;
        sum_d    = pop_c ? sum_q + d0_q : sum_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = word_count;
                    issued_d = '0;
                    sum_d    = '0;
                    busy_d   = 1'b1;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cpu_held) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (issued_q == count_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!v0_q && !v1_q && !pend_q) begin
                    state_d = S_DONE;
                    hold_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            sum_q       <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_last_q <= 1'b0;
            v0_q        <= 1'b0;
            d0_q        <= '0;
            a0_q        <= '0;
            l0_q        <= 1'b0;
            v1_q        <= 1'b0;
            d1_q        <= '0;
            a1_q        <= '0;
            l1_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            sum_q       <= sum_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_last_q <= pend_last_d;
            v0_q        <= v0_d;
            d0_q        <= d0_d;
            a0_q        <= a0_d;
            l0_q        <= l0_d;
            v1_q        <= v1_d;
            d1_q        <= d1_d;
            a1_q        <= a1_d;
            l1_q        <= l1_d;
        end
    end

    // Read port is combinational so the issue decision can see this cycle's pop.
    assign mem_ren   = issue_c;
    assign mem_addr  = rd_addr_c;
    assign cpu_hold  = hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = sum_q;
    assign out_valid = v0_q;
    assign out_data  = d0_q;
    assign out_addr  = a0_q;
    assign out_last  = l0_q;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Bench for dmem_dump_unit: memory model, stream monitor and directed/random dumps
// compared against an expected beat list computed from the window arithmetic.
module tb_dmem_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  word_count;
    logic        cpu_hold;
    logic        cpu_held;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    dmem_dump_unit #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .cpu_hold(cpu_hold), .cpu_held(cpu_held), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    int          errors = 0;
    int          checks = 0;
    int          rmode  = 0;

    logic [31:0] got_q[$];
    int          cyc_cnt = 0;
    int          n_issued, n_popped, max_out, n_done, n_hold, n_valid;
    int          first_ren, first_pop, last_pop;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_payload = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    initial begin
        int k = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    // Stream monitor: collects beats, checks stall stability, tracks outstanding words.
    always @(negedge clk) begin
        cyc_cnt++;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_payload", {7'b0, out_last, out_addr, out_data}, prev_payload);
            end
            if (mem_ren) begin
                n_issued++;
                if (first_ren < 0) first_ren = cyc_cnt;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({7'b0, out_last, out_addr, out_data});
                n_popped++;
                if (first_pop < 0) first_pop = cyc_cnt;
                last_pop = cyc_cnt;
            end
            if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
            if (done) n_done++;
            if (cpu_hold) n_hold++;
            if (out_valid) n_valid++;
            prev_stall   = out_valid && !out_ready;
            prev_payload = {7'b0, out_last, out_addr, out_data};
        end
    end

    task automatic clear_mon();
        got_q.delete();
        n_issued = 0; n_popped = 0; max_out = 0; n_done = 0; n_hold = 0; n_valid = 0;
        first_ren = -1; first_pop = -1; last_pop = -1;
    endtask

    // One dump: hd>0 keeps cpu_held low for hd cycles, injects a stray start and later drops cpu_held.
    task automatic run_dump(input string tag, input logic [7:0] b, input logic [8:0] n, input int hd);
        logic [15:0] exp_sum;
        logic [7:0]  a;
        int          cyc;
        int          lim;
        clear_mon();
        cpu_held   = (hd == 0);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (cyc < hd) begin
                check({tag, "_no_ren_hold"}, 32'(mem_ren), 32'd0);
                check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
            end
            if (hd > 0 && cyc == 3) begin
                start = 1'b1; base_addr = ~b; word_count = 9'd3;
            end else begin
                start = 1'b0;
            end
            if (cyc == hd) cpu_held = 1'b1;
            if (hd > 0 && cyc == hd + 4) cpu_held = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        cpu_held = 1'b1;
        exp_sum  = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = 8'(int'(b) + i);
            exp_sum = exp_sum + mem[a];
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
        @(posedge clk); #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_checksum_held"}, 32'(checksum), 32'(exp_sum));
        check({tag, "_n_done"}, 32'(n_done), 32'd1);
        check({tag, "_beats"}, 32'(got_q.size()), 32'(n));
        check({tag, "_max_out"}, 32'(max_out <= 2), 32'd1);
        lim = (got_q.size() < int'(n)) ? got_q.size() : int'(n);
        for (int i = 0; i < lim; i++) begin
            a = 8'(int'(b) + i);
            check($sformatf("%s_beat%0d", tag, i), got_q[i],
                  {7'b0, (i == int'(n) - 1), a, mem[a]});
        end
        if (n == 9'd0) begin
            check({tag, "_zero_latency"}, 32'(cyc), 32'd0);
            check({tag, "_zero_hold"}, 32'(n_hold), 32'd0);
            check({tag, "_zero_ren"}, 32'(n_issued), 32'd0);
            check({tag, "_zero_valid"}, 32'(n_valid), 32'd0);
        end else if (rmode == 0 && hd == 0) begin
            check({tag, "_first_latency"}, 32'(first_pop - first_ren), 32'd2);
            check({tag, "_full_rate"}, 32'(last_pop - first_pop), 32'(int'(n) - 1));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; cpu_held = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'h00A0; mem[8'h12] = 16'h00FF; mem[8'h13] = 16'h0001;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {16'b0, cpu_hold, mem_ren, out_valid, out_last, busy, done, 10'b0},
              32'd0);
        check("rst_data", {out_data, checksum}, 32'd0);
        check("rst_addr", {16'b0, mem_addr, out_addr}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        rmode = 0;
        run_dump("t1", 8'h10, 9'd4, 0);
        check("t1_sum_const", 32'(checksum), 32'h01A5);
        rmode = 1;
        run_dump("t2", 8'h10, 9'd4, 0);
        rmode = 0;
        run_dump("t3_wrap", 8'hFE, 9'd4, 0);
        rmode = 2;
        run_dump("t3_wrap_rnd", 8'hFD, 9'd6, 0);
        rmode = 0;
        run_dump("t4_zero", 8'h55, 9'd0, 0);
        check("t4_zero_sum", 32'(checksum), 32'd0);
        run_dump("t4_full", 8'h00, 9'd256, 0);
        rmode = 2;
        run_dump("t5_held", 8'h40, 9'd12, 10);
        for (int r = 0; r < 4; r++) begin
            rmode = r % 3;
            run_dump($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)),
                     9'($urandom_range(1, 40)), 0);
        end

        // Reset in the middle of a dump, then a fresh dump from a different base.
        rmode = 0;
        clear_mon();
        base_addr = 8'h30; word_count = 9'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && got_q.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        check("t6_two_emitted", 32'(got_q.size() >= 2), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_ctl", {26'b0, cpu_hold, mem_ren, out_valid, out_last, busy, done}, 32'd0);
        check("t6_rst_data", {out_data, checksum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_dump("t6_after", 8'h80, 9'd5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dump_unit.md
Name: dmem_dump_unit

Overview:
Hardware read-out engine for the simplecpu data memory. On command it halts the CPU, reads a contiguous window of data memory word by word, and streams each word, with its address, out over a valid/ready interface. It is the in-silicon counterpart of the end-of-run memory dump, and feeds a debug link or an on-chip log. It also produces a 16-bit additive checksum of the dumped window.

Parameters:
ADDR_W, 8, data memory address width (DEPTH = 2**ADDR_W = 256 words)
DATA_W, 16, data memory word width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse; accepted only in IDLE
base_addr  input  ADDR_W  first word address, sampled with start
word_count  input  ADDR_W+1  words to dump, 0..256, sampled with start
cpu_hold  output  1  request CPU stall
cpu_held  input  1  CPU acknowledges it is stalled
mem_ren  output  1  data memory read enable
mem_addr  output  ADDR_W  data memory read address
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_ren
out_valid  output  1  stream word valid
out_ready  input  1  consumer ready
out_data  output  DATA_W  dumped word
out_addr  output  ADDR_W  address of out_data
out_last  output  1  marks final word of the window
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at completion
checksum  output  DATA_W  sum mod 2**DATA_W of all emitted words, held until next start

Behaviour:
- Reset: every output is 0, state IDLE, buffer empty, checksum 0.
- States: IDLE -> HOLD -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches base_addr and word_count, clears checksum, raises busy, goes to HOLD. When word_count=0 it goes straight to DONE instead: no cpu_hold, no reads, no output, done pulses on the next cycle.
- HOLD: cpu_hold=1. Stays here until cpu_held=1, then goes to READ. cpu_hold stays high through READ and DRAIN and drops on entry to DONE.
- READ: issues at most one read per cycle. mem_addr = (base + issued) mod DEPTH, so addresses wrap from 255 to 0.
  - A read issues only when the 2-entry output buffer occupancy plus in-flight reads is below 2. No data is ever dropped.
  - When issued = word_count, go to DRAIN.
- mem_rdata is captured into the buffer the cycle after mem_ren. Each buffer entry carries its address and a last flag, where last is set when the entry index = word_count-1.
- Output handshake:
  - out_valid=1 whenever the buffer is non-empty. out_data, out_addr and out_last show the head entry.
  - A transfer occurs when out_valid and out_ready are both 1. The head pops on that cycle and checksum adds out_data.
  - While out_valid=1 and out_ready=0, out_* must stay stable.
- Throughput: with out_ready held at 1, one word per cycle. The first out_valid comes 2 cycles after entering READ.
- DRAIN: waits until the buffer is empty and no reads are in flight, then goes to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. The checksum stays valid until the next accepted start.
- start while busy=1 is ignored; the latched parameters are unchanged.
- cpu_held dropping mid-dump has no effect: the engine continues.
- rst asserted mid-operation: immediate return to reset state, outputs 0, buffer flushed, cpu_hold released asynchronously.
- Arithmetic:
  - Address arithmetic is ADDR_W-bit modulo.
  - Counters are ADDR_W+1 bits so a 256-word dump terminates correctly.
  - Checksum wraps modulo 2**DATA_W.

Test Plan:
1. Preload mem[0x10..0x13] = 0x0005, 0x00A0, 0x00FF, 0x0001; cpu_held tied 1, out_ready=1; start with base 0x10, count 4 -> 4 beats, addresses 0x10..0x13, out_last only on 0x13, checksum 0x01A5, done pulses once, cpu_hold low after done.
2. Same window with out_ready toggling 1,0,0,1,... -> the identical 4-word sequence with no loss or duplication, out_* stable while stalled, at most 2 reads outstanding+buffered.
3. Wrap: base 0xFE, count 4 -> addresses 0xFE, 0xFF, 0x00, 0x01 in order, last on 0x01.
4. count 0 -> done 1 cycle after start, no cpu_hold, no mem_ren, no out_valid, checksum 0. count 256, base 0x00 -> 256 beats, last on 0xFF.
5. cpu_held held 0 for 10 cycles after start -> no mem_ren until cpu_held rises. A second start during the dump is ignored.
6. Assert rst after 2 words emitted -> all outputs 0 immediately, cpu_hold released. A new start afterwards dumps correctly from its own base.
